// File: rtl/ultrasonic_multi_ranger.sv
// Round-robin controller for NUM_CH HC-SR04-style ultrasonic sensors.
// Each channel gets one trigger pulse, then its echo is timed and published as a result record.
module ultrasonic_multi_ranger #(
    parameter int NUM_CH              = 4,
    parameter int TRIG_CYCLES         = 500,
    parameter int ECHO_TIMEOUT_CYCLES = 1900000,
    parameter int GUARD_CYCLES        = 100000,
    parameter int CNT_W               = 21,
    parameter int SYNC_STAGES         = 2,
    localparam int CH_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ECHO,
    input  logic [CNT_W-1:0]  near_thresh,
    output logic [NUM_CH-1:0] TRIGGER,
    output logic              meas_valid,
    output logic [CH_W-1:0]   meas_ch,
    output logic [CNT_W-1:0]  meas_width,
    output logic              meas_timeout,
    output logic [NUM_CH-1:0] near_flags,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX     = CNT_W'(ECHO_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GUARD
    } state_t;

    state_t            state, state_nx;
    logic [CH_W-1:0]   ch, ch_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CNT_W-1:0]  width, width_nx;
    logic [NUM_CH-1:0] sync_ff [SYNC_STAGES];
    logic              echo_sel;
    logic              sel_q, prev_q;
    logic              rise, fall;
    logic              rep, rep_timeout;
    logic [CNT_W-1:0]  rep_width;
    logic [NUM_CH-1:0] trig_nx;

    // The selected echo is re-registered after the mux, so sel_q/prev_q always
    // compare two samples of the same channel once a trigger is under way.
    always_comb begin
        echo_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) echo_sel = sync_ff[SYNC_STAGES-1][i];
        end
    end

    assign rise = sel_q & ~prev_q;
    assign fall = ~sel_q & prev_q;

    always_comb begin
        state_nx    = state;
        ch_nx       = ch;
        cnt_nx      = cnt;
        width_nx    = width;
        rep         = 1'b0;
        rep_timeout = 1'b0;
        rep_width   = width;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = TRIG;
                    cnt_nx   = '0;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_nx = WAIT_RISE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_nx = MEASURE;
                    width_nx = CNT_W'(1);
                end else if (cnt >= TO_LAST) begin
                    rep         = 1'b1;
                    rep_timeout = 1'b1;
                    rep_width   = TO_MAX;
                    state_nx    = GUARD;
                    cnt_nx      = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    rep      = 1'b1;
                    state_nx = GUARD;
                    cnt_nx   = '0;
                end else if (sel_q) begin
                    if (width >= TO_LAST) begin
                        rep         = 1'b1;
                        rep_timeout = 1'b1;
                        rep_width   = TO_MAX;
                        width_nx    = TO_MAX;
                        state_nx    = GUARD;
                        cnt_nx      = '0;
                    end else begin
                        width_nx = width + 1'b1;
                    end
                end
            end
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    ch_nx    = (ch == CH_LAST) ? '0 : ch + 1'b1;
                    cnt_nx   = '0;
                    state_nx = enable ? TRIG : IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        trig_nx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            trig_nx[i] = (state_nx == TRIG) && (ch_nx == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ch     <= '0;
            cnt    <= '0;
            width  <= '0;
            sel_q  <= 1'b0;
            prev_q <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
        end else begin
            state  <= state_nx;
            ch     <= ch_nx;
            cnt    <= cnt_nx;
            width  <= width_nx;
            sel_q  <= echo_sel;
            prev_q <= sel_q;
            sync_ff[0] <= ECHO;
            for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
        end
    end

    // Result fields only change in the report cycle; near_flags keeps the other channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            TRIGGER      <= '0;
            meas_valid   <= 1'b0;
            meas_ch      <= '0;
            meas_width   <= '0;
            meas_timeout <= 1'b0;
            near_flags   <= '0;
            busy         <= 1'b0;
        end else begin
            TRIGGER    <= trig_nx;
            busy       <= (state_nx != IDLE);
            meas_valid <= rep;
            if (rep) begin
                meas_ch      <= ch;
                meas_width   <= rep_width;
                meas_timeout <= rep_timeout;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch == CH_W'(i)) near_flags[i] <= !rep_timeout && (rep_width < near_thresh);
                end
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_multi_ranger.sv
// Directed bench for ultrasonic_multi_ranger with shortened timing parameters.
module tb_ultrasonic_multi_ranger;

    localparam int NUM_CH = 4;
    localparam int TRIG   = 10;
    localparam int TO     = 300;
    localparam int GUARD  = 20;
    localparam int CNT_W  = 12;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NUM_CH-1:0] ECHO;
    logic [CNT_W-1:0]  near_thresh;
    logic [NUM_CH-1:0] TRIGGER;
    logic              meas_valid;
    logic [1:0]        meas_ch;
    logic [CNT_W-1:0]  meas_width;
    logic              meas_timeout;
    logic [NUM_CH-1:0] near_flags;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ultrasonic_multi_ranger #(
        .NUM_CH(NUM_CH), .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT_CYCLES(TO),
        .GUARD_CYCLES(GUARD), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ECHO(ECHO), .near_thresh(near_thresh),
        .TRIGGER(TRIGGER), .meas_valid(meas_valid), .meas_ch(meas_ch),
        .meas_width(meas_width), .meas_timeout(meas_timeout),
        .near_flags(near_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic wait_trig(output int waited);
        waited = 0;
        while (TRIGGER == '0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic trig_done();
        int n;
        n = 0;
        while (TRIGGER != '0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!meas_valid && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic pulse_echo(input int c, input int w);
        ECHO[c] = 1'b1;
        repeat (w) @(negedge clk);
        ECHO[c] = 1'b0;
    endtask

    task automatic do_round(input int c, input int w);
        int n;
        wait_trig(n);
        trig_done();
        pulse_echo(c, w);
        wait_valid(n);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; ECHO = '0; near_thresh = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (TRIGGER !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_trigger: got %b expected 0000", TRIGGER); end
        n_cmp++;
        if ({meas_valid, meas_timeout, busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {meas_valid, meas_timeout, busy}); end
        n_cmp++;
        if ({meas_ch, meas_width, near_flags} !== '0) begin n_fail++; $display("[TB] FAIL reset_result: ch %0d width %0d near %b expected all 0", meas_ch, meas_width, near_flags); end
        rst = 1'b0;
    endtask

    task automatic test_basic_ch0();
        int n, len;
        near_thresh = 12'd20;
        enable = 1'b1;
        wait_trig(n);
        n_cmp++;
        if (TRIGGER !== 4'b0001) begin n_fail++; $display("[TB] FAIL first_trigger: got %b expected 0001", TRIGGER); end
        len = 0;
        while (TRIGGER === 4'b0001 && len < 1000) begin
            len++;
            @(negedge clk);
        end
        n_cmp++;
        if (len !== TRIG) begin n_fail++; $display("[TB] FAIL trigger_len: got %0d expected %0d", len, TRIG); end
        n_cmp++;
        if (TRIGGER !== 4'b0000) begin n_fail++; $display("[TB] FAIL trigger_after: got %b expected 0000", TRIGGER); end
        pulse_echo(0, 59);
        wait_valid(n);
        n_cmp++;
        if (n !== SYNC + 2) begin n_fail++; $display("[TB] FAIL valid_latency: got %0d expected %0d", n, SYNC + 2); end
        n_cmp++;
        if ({meas_valid, meas_ch, meas_timeout} !== {1'b1, 2'd0, 1'b0}) begin n_fail++; $display("[TB] FAIL ch0_fields: valid %b ch %0d to %b expected 1 0 0", meas_valid, meas_ch, meas_timeout); end
        n_cmp++;
        if (meas_width !== 12'd59) begin n_fail++; $display("[TB] FAIL ch0_width: got %0d expected 59", meas_width); end
        n_cmp++;
        if (near_flags !== 4'b0000) begin n_fail++; $display("[TB] FAIL ch0_near: got %b expected 0000", near_flags); end
        @(negedge clk);
        n_cmp++;
        if (meas_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL valid_one_cycle: got %b expected 0", meas_valid); end
        n_cmp++;
        if (meas_width !== 12'd59) begin n_fail++; $display("[TB] FAIL width_hold: got %0d expected 59", meas_width); end
    endtask

    task automatic test_near_ch1();
        int n;
        near_thresh = 12'd50;
        wait_trig(n);
        n_cmp++;
        if (TRIGGER !== 4'b0010) begin n_fail++; $display("[TB] FAIL ch1_trigger: got %b expected 0010", TRIGGER); end
        trig_done();
        pulse_echo(1, 30);
        wait_valid(n);
        n_cmp++;
        if ({meas_valid, meas_ch, meas_width} !== {1'b1, 2'd1, 12'd30}) begin n_fail++; $display("[TB] FAIL ch1_result: valid %b ch %0d width %0d expected 1 1 30", meas_valid, meas_ch, meas_width); end
        n_cmp++;
        if (near_flags !== 4'b0010) begin n_fail++; $display("[TB] FAIL ch1_near: got %b expected 0010", near_flags); end
    endtask

    task automatic test_timeout_ch2();
        int n;
        wait_trig(n);
        n_cmp++;
        if (TRIGGER !== 4'b0100) begin n_fail++; $display("[TB] FAIL ch2_trigger: got %b expected 0100", TRIGGER); end
        trig_done();
        ECHO[3] = 1'b1;
        wait_valid(n);
        n_cmp++;
        if ({meas_valid, meas_ch, meas_timeout} !== {1'b1, 2'd2, 1'b1}) begin n_fail++; $display("[TB] FAIL ch2_fields: valid %b ch %0d to %b expected 1 2 1", meas_valid, meas_ch, meas_timeout); end
        n_cmp++;
        if (meas_width !== 12'(TO)) begin n_fail++; $display("[TB] FAIL ch2_width: got %0d expected %0d", meas_width, TO); end
        n_cmp++;
        if (near_flags !== 4'b0010) begin n_fail++; $display("[TB] FAIL ch2_near: got %b expected 0010", near_flags); end
        wait_trig(n);
        n_cmp++;
        if (n !== GUARD) begin n_fail++; $display("[TB] FAIL guard_gap: got %0d expected %0d", n, GUARD); end
        n_cmp++;
        if (TRIGGER !== 4'b1000) begin n_fail++; $display("[TB] FAIL ch3_trigger: got %b expected 1000", TRIGGER); end
    endtask

    task automatic test_stuck_ch3();
        int n;
        trig_done();
        wait_valid(n);
        n_cmp++;
        if ({meas_valid, meas_ch, meas_timeout, meas_width} !== {1'b1, 2'd3, 1'b1, 12'(TO)}) begin n_fail++; $display("[TB] FAIL ch3_stuck: valid %b ch %0d to %b width %0d expected 1 3 1 %0d", meas_valid, meas_ch, meas_timeout, meas_width, TO); end
        ECHO[3] = 1'b0;
    endtask

    task automatic test_wrap_isolation();
        int n;
        wait_trig(n);
        n_cmp++;
        if (TRIGGER !== 4'b0001) begin n_fail++; $display("[TB] FAIL wrap_trigger: got %b expected 0001", TRIGGER); end
        trig_done();
        ECHO[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ECHO[2] = i[2];
            @(negedge clk);
        end
        ECHO[0] = 1'b0;
        ECHO[2] = 1'b0;
        wait_valid(n);
        n_cmp++;
        if ({meas_valid, meas_ch, meas_timeout, meas_width} !== {1'b1, 2'd0, 1'b0, 12'd40}) begin n_fail++; $display("[TB] FAIL ch0_isolation: valid %b ch %0d to %b width %0d expected 1 0 0 40", meas_valid, meas_ch, meas_timeout, meas_width); end
        n_cmp++;
        if (near_flags !== 4'b0011) begin n_fail++; $display("[TB] FAIL ch0_near_set: got %b expected 0011", near_flags); end
    endtask

    task automatic test_flag_clear();
        do_round(1, 80);
        n_cmp++;
        if ({meas_ch, meas_width} !== {2'd1, 12'd80}) begin n_fail++; $display("[TB] FAIL ch1_far: ch %0d width %0d expected 1 80", meas_ch, meas_width); end
        n_cmp++;
        if (near_flags !== 4'b0001) begin n_fail++; $display("[TB] FAIL ch1_near_clear: got %b expected 0001", near_flags); end
    endtask

    task automatic test_reset_mid_measure();
        int n;
        do_round(2, 15);
        do_round(3, 16);
        do_round(0, 17);
        n_cmp++;
        if ({meas_ch, meas_width, near_flags} !== {2'd0, 12'd17, 4'b1101}) begin n_fail++; $display("[TB] FAIL pre_reset: ch %0d width %0d near %b expected 0 17 1101", meas_ch, meas_width, near_flags); end
        wait_trig(n);
        trig_done();
        ECHO[1] = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({TRIGGER, meas_valid, meas_ch, meas_width, meas_timeout, near_flags, busy} !== '0) begin n_fail++; $display("[TB] FAIL mid_reset: trig %b ch %0d width %0d near %b busy %b expected all 0", TRIGGER, meas_ch, meas_width, near_flags, busy); end
        ECHO[1] = 1'b0;
        rst = 1'b0;
        wait_trig(n);
        n_cmp++;
        if (TRIGGER !== 4'b0001) begin n_fail++; $display("[TB] FAIL post_reset_trigger: got %b expected 0001", TRIGGER); end
    endtask

    task automatic test_enable_drop();
        int n;
        logic seen;
        do_round(0, 10);
        n_cmp++;
        if ({meas_ch, meas_width} !== {2'd0, 12'd10}) begin n_fail++; $display("[TB] FAIL resume_ch0: ch %0d width %0d expected 0 10", meas_ch, meas_width); end
        wait_trig(n);
        trig_done();
        ECHO[1] = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (70) @(negedge clk);
        ECHO[1] = 1'b0;
        wait_valid(n);
        n_cmp++;
        if ({meas_valid, meas_ch, meas_timeout, meas_width} !== {1'b1, 2'd1, 1'b0, 12'd80}) begin n_fail++; $display("[TB] FAIL drop_result: valid %b ch %0d to %b width %0d expected 1 1 0 80", meas_valid, meas_ch, meas_timeout, meas_width); end
        repeat (GUARD - 1) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_in_guard: got %b expected 1", busy); end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_after_guard: got %b expected 0", busy); end
        seen = 1'b0;
        repeat (40) begin
            if (TRIGGER != '0) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_trigger: got %b expected 0", seen); end
        enable = 1'b1;
        wait_trig(n);
        n_cmp++;
        if (TRIGGER !== 4'b0100) begin n_fail++; $display("[TB] FAIL reenable_trigger: got %b expected 0100", TRIGGER); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_ch0();
        test_near_ch1();
        test_timeout_ch2();
        test_stuck_ch3();
        test_wrap_isolation();
        test_flag_clear();
        test_reset_mid_measure();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
